// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to enable MADD/MADDU (ops 4/5), which accumulate the product into {HI,LO}.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wd,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [2:0] OpMult = 3'd0;
    localparam logic [2:0] OpDiv  = 3'd2;
    localparam logic [2:0] OpDivu = 3'd3;
    localparam logic [2:0] OpMadd = 3'd4;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OpMaddu = 3'd5;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    function automatic logic op_signed(input logic [2:0] o);
        return (o == OpMult) || (o == OpDiv) || (o == OpMadd);
    endfunction

    function automatic logic op_div(input logic [2:0] o);
        return (o == OpDiv) || (o == OpDivu);
    endfunction

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q;
    logic [2:0]             op_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       mag_b_q;
    logic [2*WIDTH-1:0]     p_q;
    logic                   neg_prod_q;
    logic                   neg_rem_q;
    logic [WIDTH-1:0]       hi_q, lo_q;
    logic                   done_q;
    logic                   div_zero_q;

    logic                   op_legal;
    logic                   accept;
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag;

    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_diff;
    logic [2*WIDTH-1:0]     div_next;

    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;
    logic [WIDTH-1:0]       res_hi, res_lo;

`ifdef MDU_MADD_EN
    assign op_legal = (op <= OpMaddu);
`else
    assign op_legal = (op <= OpDivu);
`endif

    assign accept = (state_q == StIdle) && start && op_legal;

    // Both multiply and divide iterate on magnitudes; signs are fixed up in StFix.
    assign a_neg = op_signed(op) && a[WIDTH-1];
    assign b_neg = op_signed(op) && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // p_q holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? mag_b_q : '0)};
    assign mul_next = {mul_sum, p_q[WIDTH-1:1]};

    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    always_comb begin
        prod_fix = neg_prod_q ? -p_q : p_q;
        quo_fix  = neg_prod_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (op_div(op_q)) begin
            if (mag_b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
`ifdef MDU_MADD_EN
        if ((op_q == OpMadd) || (op_q == OpMaddu)) begin
            {res_hi, res_lo} = {hi_q, lo_q} + prod_fix;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            mag_b_q    <= '0;
            p_q        <= '0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q      <= '0;
                op_q       <= op;
                a_q        <= a;
                mag_b_q    <= b_mag;
                p_q        <= {{WIDTH{1'b0}}, a_mag};
                neg_prod_q <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q + CntW'(1);
                p_q   <= op_div(op_q) ? div_next : mul_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= (state_q == StFix);
            if (state_q == StFix) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
                if (op_div(op_q)) div_zero_q <= (mag_b_q == '0);
            end else if (state_q == StIdle) begin
                if (hilo_we[1]) hi_q <= hilo_wd;
                if (hilo_we[0]) lo_q <= hilo_wd;
            end
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: table vectors, hand-written corner sequences, random vs. arithmetic model.
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic [1:0]    hilo_we;
    logic [W-1:0]  hilo_wd;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hilo_we  (hilo_we),
        .hilo_wd  (hilo_wd),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_hi, m_lo;
    logic        m_dz;
    logic [31:0] acc_hi, acc_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference: results straight from the MIPS definitions.
    task automatic model(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] hin, input logic [31:0] lin, input logic dzin,
                         output logic [31:0] ho, output logic [31:0] lo_o, output logic dzo);
        logic [63:0] p;
        int sa, sb;
        dzo = dzin;
        p   = '0;
        sa  = ia;
        sb  = ib;
        case (o)
            3'd0, 3'd4: p = longint'(sa) * longint'(sb);
            3'd1, 3'd5: p = {32'd0, ia} * {32'd0, ib};
            default: ;
        endcase
        if (o >= 3'd4) p = p + {hin, lin};
        {ho, lo_o} = p;
        if (o == 3'd2 || o == 3'd3) begin
            dzo = (ib == 32'd0);
            if (ib == 32'd0) begin
                ho = ia;
                lo_o = '1;
            end else if (o == 3'd2 && ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF) begin
                lo_o = ia;
                ho = 32'd0;
            end else if (o == 3'd2) begin
                lo_o = sa / sb;
                ho = sa % sb;
            end else begin
                lo_o = ia / ib;
                ho = ia % ib;
            end
        end
    endtask

    // Issue one op (caller is 1 time unit after a rising edge with the unit idle) and check it.
    task automatic exec(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input string nm);
        int cycles;
        int busy_cnt;
        logic leak;
        start = 1'b1;
        op = o;
        a = ia;
        b = ib;
        @(posedge clk); #1;
        start = 1'b0;
        hilo_we = 2'b00;
        a = $urandom;
        b = $urandom;
        acc_hi = hi;
        acc_lo = lo;
        cycles = 0;
        busy_cnt = 0;
        leak = 1'b0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (hi !== acc_hi || lo !== acc_lo) leak = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        check({nm, " latency"}, cycles, 33);
        check({nm, " busy cycles"}, busy_cnt, 33);
        check({nm, " hi/lo held while busy"}, leak, 0);
        check({nm, " hi"}, hi, ehi);
        check({nm, " lo"}, lo, elo);
        check({nm, " div_zero"}, div_zero, edz);
        m_hi = ehi;
        m_lo = elo;
        m_dz = edz;
    endtask

    task automatic reserved(input logic [2:0] o);
        logic [31:0] phi, plo;
        logic saw_busy;
        phi = hi;
        plo = lo;
        saw_busy = 1'b0;
        start = 1'b1;
        op = o;
        a = 32'd2;
        b = 32'd3;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy) saw_busy = 1'b1;
        end
        start = 1'b0;
        check($sformatf("reserved op %0d busy", o), saw_busy, 0);
        check($sformatf("reserved op %0d hi/lo", o), {hi, lo}, {phi, plo});
    endtask

    initial begin
        logic [31:0] ehi, elo;
        logic edz, saw_done;
        logic [2:0] ro;
        logic [31:0] ra, rb;
        int cnt;

        vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult -3*7"};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, "multu max"};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2"};
        vecs[3] = '{3'd3, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1, "divu by 0"};
        vecs[4] = '{3'd0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1, "mult keeps dz"};
        vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "div min/-1"};
        vecs[6] = '{3'd3, 32'hFFFF_FFFF, 32'd16, 32'hF, 32'h0FFF_FFFF, 1'b0, "divu max/16"};
        vecs[7] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, "div 7/-2"};
        vecs[8] = '{3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div -7/0"};

        rst = 1'b0;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        hilo_we = 2'b00;
        hilo_wd = '0;
        #3;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back table: each op is issued in the previous op's done cycle.
        for (int i = 0; i < 9; i++) begin
            exec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].name);
        end

        // Reset in the middle of a multiply.
        start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset hi", hi, 0);
        check("midreset lo", lo, 0);
        check("midreset div_zero", div_zero, 0);
        @(posedge clk); #1 rst = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("midreset no done", saw_done, 0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        exec(3'd0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "mult after reset");

        // MTHI/MTLO and start while busy are ignored; exactly one done.
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        hilo_we = 2'b11; hilo_wd = 32'h1234;
        start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
        repeat (4) begin @(posedge clk); #1; end
        hilo_we = 2'b00;
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("busy-write done latency", cnt, 27);
        check("busy-write hi", hi, 32'd0);
        check("busy-write lo", lo, 32'd6);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("no second done", saw_done, 0);

        // Idle MTHI/MTLO.
        hilo_we = 2'b11; hilo_wd = 32'h1234;
        @(posedge clk); #1;
        hilo_we = 2'b10; hilo_wd = 32'hABCD;
        check("mthi/mtlo hi", hi, 32'h1234);
        check("mthi/mtlo lo", lo, 32'h1234);
        @(posedge clk); #1;
        hilo_we = 2'b00;
        check("mthi only hi", hi, 32'hABCD);
        check("mthi only lo", lo, 32'h1234);
        m_hi = 32'hABCD; m_lo = 32'h1234;

        // Write and start on the same idle edge: write lands, result overwrites at done.
        hilo_we = 2'b11; hilo_wd = 32'h55;
        exec(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, m_dz, "write+start");
        check("write+start early hi", acc_hi, 32'h55);
        check("write+start early lo", acc_lo, 32'h55);

        reserved(3'd6);
        reserved(3'd7);
`ifdef MDU_MADD_EN
        hilo_we = 2'b11; hilo_wd = 32'd5;
        @(posedge clk); #1;
        hilo_we = 2'b00;
        exec(3'd4, 32'd2, 32'd3, 32'd5, 32'hB, m_dz, "madd 2*3");
`else
        reserved(3'd4);
        reserved(3'd5);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
            ro = 3'($urandom_range(0, 5));
`else
            ro = 3'($urandom_range(0, 3));
`endif
            case ($urandom_range(0, 3))
                0: ra = $urandom_range(0, 40);
                1: ra = -$urandom_range(1, 40);
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2, 3: rb = $urandom_range(1, 20);
                4: rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, m_hi, m_lo, m_dz, ehi, elo, edz);
            exec(ro, ra, rb, ehi, elo, edz, $sformatf("rand%0d op%0d", i, ro));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
